// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO input conditioning path.
package gpio_pkg;

    // Default number of pins in the GPIO status bank.
    localparam int GPIO_BANK_WIDTH = 3;

    // Default number of cycles a new level must persist before acceptance.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Stability counter width: max(1, clog2(n)); holds values up to n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : gpio_pkg

// File: rtl/gpio_debounce_bit.sv
// Single-pin conditioner: two-flop synchronizer, stability-counter debouncer,
// registered rise/fall pulses and a sticky, clearable event flag.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic io_clock,
    input  logic io_resetn,
    input  logic pinIn,
    input  logic clear,
    output logic pinOut,
    output logic rise,
    output logic fall,
    output logic eventPending
);

    localparam int               CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          differs;
    logic          accept;

    // Bring the asynchronous pad level into the clock domain.
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            // NOTE: non-blocking assignments so sync2 takes the old sync1,
            // forming a real two-stage shift rather than a single flop.
            sync1 <= pinIn;
            sync2 <= sync1;
        end
    end

    // Decide whether the synchronized level has persisted long enough.
    always_comb begin
        differs = (sync2 != stable);
        accept  = differs && (cnt == CNT_LAST);
    end

    // Stability counter: restart on any agreement, latch new level on expiry.
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            stable <= RESET_VALUE;
            cnt    <= '0;
        end else if (!differs) begin
            cnt    <= '0;
        end else if (accept) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CW'(1);
        end
    end

    // Edge pulses coincide with the new level appearing on pinOut.
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept &  sync2;
            fall <= accept & ~sync2;
        end
    end

    // Sticky event flag; a same-cycle edge beats a clear.
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            eventPending <= 1'b0;
        end else if (rise || fall) begin
            eventPending <= 1'b1;
        end else if (clear) begin
            eventPending <= 1'b0;
        end
    end

    assign pinOut = stable;

endmodule : gpio_debounce_bit

// File: rtl/gpio_input_conditioner.sv
// GPIO status bank input conditioner: one independent debounce lane per pin,
// feeding the SoC pins_read input.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int               WIDTH           = GPIO_BANK_WIDTH,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             io_clock,
    input  logic             io_resetn,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] event_pending,
    input  logic [WIDTH-1:0] event_clear
);

    // One lane per pin; the top only fans buses in and out.
    for (genvar i = 0; i < WIDTH; i++) begin : genPin
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) uBit (
            .io_clock     (io_clock),
            .io_resetn    (io_resetn),
            .pinIn        (pins_in[i]),
            .clear        (event_clear[i]),
            .pinOut       (pins_out[i]),
            .rise         (rise[i]),
            .fall         (fall[i]),
            .eventPending (event_pending[i])
        );
    end

endmodule : gpio_input_conditioner

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner (WIDTH=3, DEBOUNCE_CYCLES=4).
module tb_gpio_input_conditioner;

    localparam int         W  = 3;
    localparam int         D  = 4;
    localparam logic [2:0] RV = 3'b000;

    logic         clk;
    logic         rstn;
    logic [W-1:0] pinsIn;
    logic [W-1:0] pinsOut;
    logic [W-1:0] riseOut;
    logic [W-1:0] fallOut;
    logic [W-1:0] pendOut;
    logic [W-1:0] eventClear;

    int passed = 0;
    int total  = 0;

    gpio_input_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .RESET_VALUE     (RV)
    ) dut (
        .io_clock      (clk),
        .io_resetn     (rstn),
        .pins_in       (pinsIn),
        .pins_out      (pinsOut),
        .rise          (riseOut),
        .fall          (fallOut),
        .event_pending (pendOut),
        .event_clear   (eventClear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a pin's output flips once the last D synchronized
    // samples all disagree with the accepted level.
    logic [W-1:0] s1M, s2M, stableM, riseM, fallM, pendM;
    logic         winM [W][D];

    task automatic modelReset();
        s1M = RV; s2M = RV; stableM = RV;
        riseM = '0; fallM = '0; pendM = '0;
        for (int i = 0; i < W; i++)
            for (int k = 0; k < D; k++)
                winM[i][k] = RV[i];
    endtask

    task automatic modelEdge(input logic [W-1:0] pad, input logic [W-1:0] clr);
        logic [W-1:0] newRise, newFall, newStable;
        logic allDiff;
        newRise = '0; newFall = '0; newStable = stableM;
        for (int i = 0; i < W; i++) begin
            for (int k = D - 1; k > 0; k--) winM[i][k] = winM[i][k-1];
            winM[i][0] = s2M[i];
            allDiff = 1'b1;
            for (int k = 0; k < D; k++)
                if (winM[i][k] == stableM[i]) allDiff = 1'b0;
            if (allDiff) begin
                newStable[i] = s2M[i];
                newRise[i]   = s2M[i];
                newFall[i]   = ~s2M[i];
            end
        end
        pendM   = riseM | fallM | (pendM & ~clr);
        riseM   = newRise;
        fallM   = newFall;
        stableM = newStable;
        s2M     = s1M;
        s1M     = pad;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: update the model with the held inputs, then compare on the falling edge.
    task automatic step(input string tag);
        modelEdge(pinsIn, eventClear);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pins_out"}, 32'(pinsOut), 32'(stableM));
        check({tag, "_rise"},     32'(riseOut), 32'(riseM));
        check({tag, "_fall"},     32'(fallOut), 32'(fallM));
        check({tag, "_pending"},  32'(pendOut), 32'(pendM));
    endtask

    typedef struct {
        logic [2:0] pins;
        logic [2:0] clr;
        logic [2:0] expOut;
        logic [2:0] expRise;
        logic [2:0] expFall;
        logic [2:0] expPend;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int pulses;
        int n;
        bit found;

        // Clean rise of pin 0: vector j applied before edge j, checked after it.
        for (int j = 0; j < 8; j++) begin
            vecs[j].pins    = 3'b001;
            vecs[j].clr     = 3'b000;
            vecs[j].expOut  = (j >= 5) ? 3'b001 : 3'b000;
            vecs[j].expRise = (j == 5) ? 3'b001 : 3'b000;
            vecs[j].expFall = 3'b000;
            vecs[j].expPend = (j >= 6) ? 3'b001 : 3'b000;
        end

        // Reset release
        rstn = 1'b0; pinsIn = '0; eventClear = '0;
        modelReset();
        repeat (3) @(negedge clk);
        check("reset_pins_out", 32'(pinsOut), 0);
        check("reset_pulses",   32'(riseOut | fallOut), 0);
        check("reset_pending",  32'(pendOut), 0);
        rstn = 1'b1;
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            step("idle");
            pulses += $countones(riseOut | fallOut);
        end
        check("idle_no_pulses", 32'(pulses), 0);

        // Clean rise, table-driven
        for (int j = 0; j < 8; j++) begin
            pinsIn = vecs[j].pins;
            eventClear = vecs[j].clr;
            step("rise_tbl");
            check($sformatf("tbl%0d_out",  j), 32'(pinsOut), 32'(vecs[j].expOut));
            check($sformatf("tbl%0d_rise", j), 32'(riseOut), 32'(vecs[j].expRise));
            check($sformatf("tbl%0d_fall", j), 32'(fallOut), 32'(vecs[j].expFall));
            check($sformatf("tbl%0d_pend", j), 32'(pendOut), 32'(vecs[j].expPend));
        end

        // Glitch shorter than the debounce window on pin 1
        pulses = 0;
        pinsIn = 3'b011;
        repeat (D - 1) begin
            step("glitch");
            pulses += int'(riseOut[1]) + int'(fallOut[1]);
        end
        pinsIn = 3'b001;
        repeat (8) begin
            step("glitch");
            pulses += int'(riseOut[1]) + int'(fallOut[1]);
        end
        check("glitch_pins_out1", 32'(pinsOut[1]), 0);
        check("glitch_no_pulses", 32'(pulses), 0);
        check("glitch_cnt_zero",  32'(dut.genPin[1].uBit.cnt), 0);

        // Simultaneous edges: move to 3'b100, then to 3'b001
        pinsIn = 3'b100;
        repeat (10) step("simul_setup");
        check("simul_start", 32'(pinsOut), 32'(3'b100));
        pinsIn = 3'b001;
        found = 0;
        for (int j = 0; j < 12 && !found; j++) begin
            step("simul");
            if (riseOut[0]) begin
                found = 1;
                check("simul_fall2_same_cycle", 32'(fallOut[2]), 1);
                check("simul_pins_out", 32'(pinsOut), 32'(3'b001));
            end
        end
        check("simul_rise_seen", 32'(found), 1);

        // Clear coinciding with a new fall on pin 0
        pinsIn = 3'b000;
        found = 0;
        for (int j = 0; j < 12 && !found; j++) begin
            step("clr_wait");
            if (fallOut[0]) found = 1;
        end
        check("clr_fall_seen", 32'(found), 1);
        check("clr_pend_before", 32'(pendOut[0]), 1);
        eventClear = 3'b001;
        step("clr_vs_set");
        eventClear = 3'b000;
        check("clr_set_wins", 32'(pendOut[0]), 1);
        step("clr_hold");
        eventClear = 3'b001;
        step("clr_lone");
        eventClear = 3'b000;
        check("clr_lone_drop", 32'(pendOut[0]), 0);
        step("clr_after");

        // Asynchronous reset in the middle of a count on pin 2
        pinsIn = 3'b100;
        found = 0;
        for (int j = 0; j < 10 && !found; j++) begin
            step("midrst_wait");
            if (dut.genPin[2].uBit.cnt == 2) found = 1;
        end
        check("midrst_cnt_reached", 32'(found), 1);
        check("midrst_pend_before", 32'(pendOut[2]), 1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_pins_out", 32'(pinsOut), 0);
        check("midrst_pending",  32'(pendOut), 0);
        check("midrst_pulses",   32'(riseOut | fallOut), 0);
        check("midrst_cnt",      32'(dut.genPin[2].uBit.cnt), 0);
        @(negedge clk);
        rstn = 1'b1;
        modelReset();
        n = 0;
        pulses = 0;
        for (int j = 1; j <= 12 && n == 0; j++) begin
            step("midrst_recover");
            pulses += int'(riseOut[2]);
            if (pinsOut[2]) n = j;
        end
        check("midrst_latency", 32'(n), 32'(2 + D));
        repeat (4) begin
            step("midrst_tail");
            pulses += int'(riseOut[2]);
        end
        check("midrst_one_rise", 32'(pulses), 1);

        // Randomized traffic against the model, with one reset in the middle
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(7) == 0) pinsIn[i] = ~pinsIn[i];
            for (int i = 0; i < W; i++)
                eventClear[i] = ($urandom_range(3) == 0);
            if (c == 700) begin
                rstn = 1'b0;
                modelReset();
                #1;
                check("rand_reset_out", 32'({pinsOut, riseOut, fallOut, pendOut}), 0);
                @(negedge clk);
                rstn = 1'b1;
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_gpio_input_conditioner
